rv32i_mc_controller_v2: RTL and testbench

//  Multicycle RV32I control FSM, successor to the first-generation controller. Decodes the instruction register
//  and drives datapath selects and strobes. Adds the following over the first generation:
//  LUI, AUIPC and JALR; unsigned and overflow-correct signed branches; a memory ready handshake;

---
 rtl/rv32i_pkg.sv | 61 ++++++
 rtl/ALUDecoder.sv | 37 +++
 rtl/rv32_branch_eval.sv | 29 ++
 rtl/rv32i_mc_controller_v2.sv | 186 ++++++++++++++++++
 tb/tb_rv32i_mc_controller_v2.sv | 336 +++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/rv32i_pkg.sv
// Shared RV32I control definitions: opcodes, controller states, ALU operation
// codes and the datapath select encodings driven by the multicycle controller.
package rv32i_pkg;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_OP     = 7'b0110011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;

    typedef enum logic [3:0] {
        S_FETCH     = 4'd0,
        S_DECODE    = 4'd1,
        S_MEM_ADDR  = 4'd2,
        S_MEM_READ  = 4'd3,
        S_MEM_WB    = 4'd4,
        S_MEM_WRITE = 4'd5,
        S_EXEC_R    = 4'd6,
        S_EXEC_I    = 4'd7,
        S_ALU_WB    = 4'd8,
        S_JAL       = 4'd9,
        S_JALR_ADDR = 4'd10,
        S_JALR      = 4'd11,
        S_LUI       = 4'd12,
        S_BRANCH    = 4'd13,
        S_TRAP      = 4'd14
    } ctrl_state_t;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

    localparam logic [1:0] RES_ALUOUT = 2'b00;
    localparam logic [1:0] RES_MEM    = 2'b01;
    localparam logic [1:0] RES_ALURES = 2'b10;

    localparam logic [1:0] SRCA_PC    = 2'b00;
    localparam logic [1:0] SRCA_OLDPC = 2'b01;
    localparam logic [1:0] SRCA_RS1   = 2'b10;
    localparam logic [1:0] SRCA_ZERO  = 2'b11;

    localparam logic [1:0] SRCB_RS2  = 2'b00;
    localparam logic [1:0] SRCB_IMM  = 2'b01;
    localparam logic [1:0] SRCB_FOUR = 2'b10;

    localparam logic [3:0] ALU_ADD  = 4'd0;
    localparam logic [3:0] ALU_SUB  = 4'd1;
    localparam logic [3:0] ALU_AND  = 4'd2;
    localparam logic [3:0] ALU_OR   = 4'd3;
    localparam logic [3:0] ALU_XOR  = 4'd4;
    localparam logic [3:0] ALU_SLT  = 4'd5;
    localparam logic [3:0] ALU_SLTU = 4'd6;
    localparam logic [3:0] ALU_SLL  = 4'd7;
    localparam logic [3:0] ALU_SRL  = 4'd8;
    localparam logic [3:0] ALU_SRA  = 4'd9;

endpackage

// File: rtl/ALUDecoder.sv
// Maps the controller's ALUop and instruction fields to an ALU operation code.
module ALUDecoder
    import rv32i_pkg::*;
#(
    parameter int W = 4
) (
    input  logic [1:0]   alu_op,
    input  logic [2:0]   funct3,
    input  logic         op5,
    input  logic         funct7b5,
    output logic [W-1:0] alu_control
);
    logic [3:0] code;

    always_comb begin
        code = ALU_ADD;
        case (alu_op)
            ALUOP_SUB: code = ALU_SUB;
            ALUOP_FUNCT: begin
                case (funct3)
                    // Only register-register ops (op5=1) can select subtract.
                    3'b000:  code = (op5 && funct7b5) ? ALU_SUB : ALU_ADD;
                    3'b001:  code = ALU_SLL;
                    3'b010:  code = ALU_SLT;
                    3'b011:  code = ALU_SLTU;
                    3'b100:  code = ALU_XOR;
                    3'b101:  code = funct7b5 ? ALU_SRA : ALU_SRL;
                    3'b110:  code = ALU_OR;
                    default: code = ALU_AND;
                endcase
            end
            default: code = ALU_ADD;
        endcase
    end

    assign alu_control = W'(code);
endmodule

// File: rtl/rv32_branch_eval.sv
// Branch condition evaluation from the flags of rs1 - rs2.
// carry=1 means no borrow, so carry=0 is the unsigned less-than case.
module rv32_branch_eval #(
    parameter int USE_OVF = 1
) (
    input  logic [2:0] funct3,
    input  logic       zero,
    input  logic       negative,
    input  logic       overflow,
    input  logic       carry,
    output logic       taken
);
    logic lt;

    assign lt = negative ^ ((USE_OVF != 0) ? overflow : 1'b0);

    always_comb begin
        taken = 1'b0;
        case (funct3)
            3'b000:  taken = zero;
            3'b001:  taken = !zero;
            3'b100:  taken = lt;
            3'b101:  taken = !lt;
            3'b110:  taken = !carry;
            3'b111:  taken = carry;
            default: taken = 1'b0;
        endcase
    end
endmodule

// File: rtl/rv32i_mc_controller_v2.sv
// Multicycle RV32I control FSM: decodes the instruction register and drives the
// shared datapath selects/strobes, with memory handshake and illegal-opcode trap.
module rv32i_mc_controller_v2
    import rv32i_pkg::*;
#(
    parameter int HAS_MEM_HANDSHAKE = 1,
    parameter int BRANCH_USE_OVF    = 1,
    parameter int TRAP_ON_ILLEGAL   = 1,
    parameter int ALUCTRL_W         = 4
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [31:0]          instruction,
    input  logic                 zero,
    input  logic                 negative,
    input  logic                 overflow,
    input  logic                 carry,
    input  logic                 mem_ready,
    output logic                 pc_write,
    output logic                 AdrSrc,
    output logic                 MemWrite,
    output logic                 IRWrite,
    output logic                 RegWrite,
    output logic                 mem_req,
    output logic [1:0]           ResultSrc,
    output logic [1:0]           ALUSrca,
    output logic [1:0]           ALUSrcb,
    output logic [ALUCTRL_W-1:0] ALUControl,
    output logic [1:0]           mem_size,
    output logic                 mem_unsigned,
    output logic                 illegal,
    output logic [3:0]           state
);
    ctrl_state_t cur, nxt;
    logic [6:0]  opcode;
    logic [2:0]  funct3;
    logic [1:0]  alu_op;
    logic        rdy;
    logic        taken;
    logic        unused_ir;

    assign opcode    = instruction[6:0];
    assign funct3    = instruction[14:12];
    assign rdy       = (HAS_MEM_HANDSHAKE != 0) ? mem_ready : 1'b1;
    assign state     = cur;
    assign unused_ir = ^{instruction[31], instruction[29:15], instruction[11:7]};

    rv32_branch_eval #(.USE_OVF(BRANCH_USE_OVF)) u_branch (
        .funct3  (funct3),
        .zero    (zero),
        .negative(negative),
        .overflow(overflow),
        .carry   (carry),
        .taken   (taken)
    );

    ALUDecoder #(.W(ALUCTRL_W)) u_alu_dec (
        .alu_op     (alu_op),
        .funct3     (funct3),
        .op5        (instruction[5]),
        .funct7b5   (instruction[30]),
        .alu_control(ALUControl)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) cur <= S_FETCH;
        else        cur <= nxt;
    end

    always_comb begin
        nxt          = cur;
        pc_write     = 1'b0;
        AdrSrc       = 1'b0;
        MemWrite     = 1'b0;
        IRWrite      = 1'b0;
        RegWrite     = 1'b0;
        mem_req      = 1'b0;
        ResultSrc    = RES_ALUOUT;
        ALUSrca      = SRCA_PC;
        ALUSrcb      = SRCB_RS2;
        alu_op       = ALUOP_ADD;
        mem_size     = 2'b00;
        mem_unsigned = 1'b0;
        illegal      = 1'b0;
        case (cur)
            S_FETCH: begin
                mem_req   = 1'b1;
                ALUSrcb   = SRCB_FOUR;
                ResultSrc = RES_ALURES;
                IRWrite   = rdy;
                pc_write  = rdy;
                if (rdy) nxt = S_DECODE;
            end
            S_DECODE: begin
                // ALUOut <= oldPC + imm serves AUIPC, JAL and branch targets
                ALUSrca = SRCA_OLDPC;
                ALUSrcb = SRCB_IMM;
                case (opcode)
                    OP_LOAD, OP_STORE: nxt = S_MEM_ADDR;
                    OP_OP:             nxt = S_EXEC_R;
                    OP_IMM:            nxt = S_EXEC_I;
                    OP_JAL:            nxt = S_JAL;
                    OP_JALR:           nxt = S_JALR_ADDR;
                    OP_LUI:            nxt = S_LUI;
                    OP_AUIPC:          nxt = S_ALU_WB;
                    OP_BRANCH:         nxt = S_BRANCH;
                    default:           nxt = S_TRAP;
                endcase
            end
            S_MEM_ADDR: begin
                ALUSrca  = SRCA_RS1;
                ALUSrcb  = SRCB_IMM;
                mem_size = funct3[1:0];
                nxt      = (opcode == OP_LOAD) ? S_MEM_READ : S_MEM_WRITE;
            end
            S_MEM_READ: begin
                mem_req      = 1'b1;
                AdrSrc       = 1'b1;
                mem_size     = funct3[1:0];
                mem_unsigned = funct3[2];
                if (rdy) nxt = S_MEM_WB;
            end
            S_MEM_WB: begin
                ResultSrc = RES_MEM;
                RegWrite  = 1'b1;
                mem_size  = funct3[1:0];
                nxt       = S_FETCH;
            end
            S_MEM_WRITE: begin
                mem_req  = 1'b1;
                AdrSrc   = 1'b1;
                MemWrite = 1'b1;
                mem_size = funct3[1:0];
                if (rdy) nxt = S_FETCH;
            end
            S_EXEC_R: begin
                ALUSrca = SRCA_RS1;
                ALUSrcb = SRCB_RS2;
                alu_op  = ALUOP_FUNCT;
                nxt     = S_ALU_WB;
            end
            S_EXEC_I: begin
                ALUSrca = SRCA_RS1;
                ALUSrcb = SRCB_IMM;
                alu_op  = ALUOP_FUNCT;
                nxt     = S_ALU_WB;
            end
            S_LUI: begin
                ALUSrca = SRCA_ZERO;
                ALUSrcb = SRCB_IMM;
                nxt     = S_ALU_WB;
            end
            S_JAL, S_JALR: begin
                // PC takes the target held in ALUOut while ALU computes oldPC+4
                ALUSrca   = SRCA_OLDPC;
                ALUSrcb   = SRCB_FOUR;
                ResultSrc = RES_ALUOUT;
                pc_write  = 1'b1;
                nxt       = S_ALU_WB;
            end
            S_JALR_ADDR: begin
                ALUSrca = SRCA_RS1;
                ALUSrcb = SRCB_IMM;
                nxt     = S_JALR;
            end
            S_ALU_WB: begin
                ResultSrc = RES_ALUOUT;
                RegWrite  = 1'b1;
                nxt       = S_FETCH;
            end
            S_BRANCH: begin
                ALUSrca   = SRCA_RS1;
                ALUSrcb   = SRCB_RS2;
                alu_op    = ALUOP_SUB;
                ResultSrc = RES_ALUOUT;
                pc_write  = taken;
                nxt       = S_FETCH;
            end
            S_TRAP: begin
                illegal = 1'b1;
                if (TRAP_ON_ILLEGAL == 0) nxt = S_FETCH;
            end
            default: nxt = S_FETCH;
        endcase
    end
endmodule

// File: tb/tb_rv32i_mc_controller_v2.sv
// Bench for rv32i_mc_controller_v2: instance 0 uses the default parameters, instance 1
// has handshake, overflow-corrected branches and trap parking all disabled.
module tb_rv32i_mc_controller_v2;
    import rv32i_pkg::*;

    typedef struct packed {
        logic       pc_write, adr_src, mem_write, ir_write, reg_write, mem_req;
        logic [1:0] result_src, src_a, src_b;
        logic [3:0] alu_ctrl;
        logic [1:0] mem_size;
        logic       mem_unsigned, illegal;
        logic [3:0] state;
    } ctrl_t;

    typedef struct {
        logic [2:0] f3;
        logic       z, n, v, c;
        logic       taken0, taken1;
    } br_vec_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] instr [2];
    logic        zf [2];
    logic        nf [2];
    logic        vf [2];
    logic        cf [2];
    logic        mrdy [2];
    ctrl_t       act [2];
    int          n_chk = 0;
    int          n_fail = 0;

    always #5 clk = ~clk;

    for (genvar g = 0; g < 2; g++) begin : g_dut
        logic       pcw, adr, mw, irw, rw, mreq, uns, ill;
        logic [1:0] rs, sa, sb, msz;
        logic [3:0] alu, st;
        rv32i_mc_controller_v2 #(
            .HAS_MEM_HANDSHAKE((g == 0) ? 1 : 0),
            .BRANCH_USE_OVF   ((g == 0) ? 1 : 0),
            .TRAP_ON_ILLEGAL  ((g == 0) ? 1 : 0),
            .ALUCTRL_W        (4)
        ) u_dut (
            .clk(clk), .reset(rst_n), .instruction(instr[g]),
            .zero(zf[g]), .negative(nf[g]), .overflow(vf[g]), .carry(cf[g]),
            .mem_ready(mrdy[g]), .pc_write(pcw), .AdrSrc(adr), .MemWrite(mw),
            .IRWrite(irw), .RegWrite(rw), .mem_req(mreq), .ResultSrc(rs),
            .ALUSrca(sa), .ALUSrcb(sb), .ALUControl(alu), .mem_size(msz),
            .mem_unsigned(uns), .illegal(ill), .state(st)
        );
        assign act[g] = {pcw, adr, mw, irw, rw, mreq, rs, sa, sb, alu, msz, uns, ill, st};
    end

    task automatic chk(string nm, logic [31:0] a, logic [31:0] e);
        n_chk++;
        if (a !== e) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, a, e);
        end
    endtask

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    // ALU operation named by the R/I-type mnemonic
    function automatic logic [3:0] exp_alu(logic [31:0] ins, bit is_r);
        case (ins[14:12])
            3'b000:  return (is_r && ins[30]) ? ALU_SUB : ALU_ADD;
            3'b001:  return ALU_SLL;
            3'b010:  return ALU_SLT;
            3'b011:  return ALU_SLTU;
            3'b100:  return ALU_XOR;
            3'b101:  return ins[30] ? ALU_SRA : ALU_SRL;
            3'b110:  return ALU_OR;
            default: return ALU_AND;
        endcase
    endfunction

    function automatic logic exp_taken(logic [2:0] f3, logic z, logic n, logic v, logic c, bit ovf);
        logic lt_signed;
        lt_signed = ovf ? (n != v) : n;
        case (f3)
            3'b000:  return z;
            3'b001:  return !z;
            3'b100:  return lt_signed;
            3'b101:  return !lt_signed;
            3'b110:  return !c;
            3'b111:  return c;
            default: return 1'b0;
        endcase
    endfunction

    function automatic ctrl_t exp_ctrl(ctrl_state_t st, logic [31:0] ins, logic z, logic n,
                                       logic v, logic c, logic rdy, bit ovf);
        ctrl_t e;
        e = '0;
        e.state    = st;
        e.alu_ctrl = ALU_ADD;
        case (st)
            S_FETCH:     begin e.mem_req = 1; e.src_b = 2; e.result_src = 2; e.ir_write = rdy; e.pc_write = rdy; end
            S_DECODE:    begin e.src_a = 1; e.src_b = 1; end
            S_MEM_ADDR:  begin e.src_a = 2; e.src_b = 1; e.mem_size = ins[13:12]; end
            S_MEM_READ:  begin e.mem_req = 1; e.adr_src = 1; e.mem_size = ins[13:12]; e.mem_unsigned = ins[14]; end
            S_MEM_WB:    begin e.result_src = 1; e.reg_write = 1; e.mem_size = ins[13:12]; end
            S_MEM_WRITE: begin e.mem_req = 1; e.adr_src = 1; e.mem_write = 1; e.mem_size = ins[13:12]; end
            S_EXEC_R:    begin e.src_a = 2; e.src_b = 0; e.alu_ctrl = exp_alu(ins, 1); end
            S_EXEC_I:    begin e.src_a = 2; e.src_b = 1; e.alu_ctrl = exp_alu(ins, 0); end
            S_ALU_WB:    e.reg_write = 1;
            S_JAL, S_JALR: begin e.src_a = 1; e.src_b = 2; e.pc_write = 1; end
            S_JALR_ADDR: begin e.src_a = 2; e.src_b = 1; end
            S_LUI:       begin e.src_a = 3; e.src_b = 1; end
            S_BRANCH:    begin e.src_a = 2; e.alu_ctrl = ALU_SUB; e.pc_write = exp_taken(ins[14:12], z, n, v, c, ovf); end
            S_TRAP:      e.illegal = 1;
            default:     e = '0;
        endcase
        return e;
    endfunction

    // Expected walk of one instruction through the controller, starting at FETCH
    ctrl_state_t seq [2][6];
    int          seq_len [2];
    int          seq_pos [2];

    task automatic build_path(int d, logic [31:0] ins);
        seq[d][0] = S_FETCH;
        seq[d][1] = S_DECODE;
        seq_len[d] = 4;
        seq_pos[d] = 0;
        case (ins[6:0])
            OP_LOAD:   begin seq[d][2] = S_MEM_ADDR; seq[d][3] = S_MEM_READ; seq[d][4] = S_MEM_WB; seq_len[d] = 5; end
            OP_STORE:  begin seq[d][2] = S_MEM_ADDR; seq[d][3] = S_MEM_WRITE; end
            OP_OP:     begin seq[d][2] = S_EXEC_R; seq[d][3] = S_ALU_WB; end
            OP_IMM:    begin seq[d][2] = S_EXEC_I; seq[d][3] = S_ALU_WB; end
            OP_JAL:    begin seq[d][2] = S_JAL; seq[d][3] = S_ALU_WB; end
            OP_JALR:   begin seq[d][2] = S_JALR_ADDR; seq[d][3] = S_JALR; seq[d][4] = S_ALU_WB; seq_len[d] = 5; end
            OP_LUI:    begin seq[d][2] = S_LUI; seq[d][3] = S_ALU_WB; end
            OP_AUIPC:  begin seq[d][2] = S_ALU_WB; seq_len[d] = 3; end
            OP_BRANCH: begin seq[d][2] = S_BRANCH; seq_len[d] = 3; end
            default:   begin seq[d][2] = S_TRAP; seq_len[d] = 3; end
        endcase
    endtask

    function automatic logic [31:0] rand_instr(bit allow_illegal);
        int          k;
        logic [31:0] r;
        logic [6:0]  op;
        k = $urandom_range(0, allow_illegal ? 9 : 8);
        r = $urandom();
        case (k)
            0:       op = OP_LOAD;
            1:       op = OP_STORE;
            2:       op = OP_OP;
            3:       op = OP_IMM;
            4:       op = OP_JAL;
            5:       op = OP_JALR;
            6:       op = OP_LUI;
            7:       op = OP_AUIPC;
            8:       op = OP_BRANCH;
            default: op = r[0] ? 7'b1111111 : 7'b0001111;
        endcase
        return {r[31:7], op};
    endfunction

    task automatic set_all(logic [31:0] ins, logic z, logic n, logic v, logic c, logic r);
        for (int d = 0; d < 2; d++) begin
            instr[d] = ins; zf[d] = z; nf[d] = n; vf[d] = v; cf[d] = c; mrdy[d] = r;
        end
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
        for (int d = 0; d < 2; d++)
            chk("reset_state", 32'(act[d]), 32'(exp_ctrl(S_FETCH, instr[d], zf[d], nf[d], vf[d], cf[d], mrdy[d] | (d == 1), d == 0)));
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        br_vec_t     bv [13];
        ctrl_state_t es [6];
        logic        rdy;
        bit          need_new [2];

        bv[0]  = '{3'b110, 0, 0, 0, 0, 1, 1};  // bltu, borrow
        bv[1]  = '{3'b110, 0, 0, 0, 1, 0, 0};
        bv[2]  = '{3'b111, 0, 0, 0, 1, 1, 1};  // bgeu
        bv[3]  = '{3'b101, 0, 1, 1, 0, 1, 0};  // bge N=1 V=1
        bv[4]  = '{3'b100, 0, 1, 0, 0, 1, 1};
        bv[5]  = '{3'b100, 0, 1, 1, 0, 0, 1};
        bv[6]  = '{3'b100, 0, 0, 1, 0, 1, 0};
        bv[7]  = '{3'b000, 1, 0, 0, 1, 1, 1};
        bv[8]  = '{3'b000, 0, 0, 0, 1, 0, 0};
        bv[9]  = '{3'b001, 0, 0, 0, 1, 1, 1};
        bv[10] = '{3'b001, 1, 0, 0, 1, 0, 0};
        bv[11] = '{3'b010, 1, 1, 0, 1, 0, 0};
        bv[12] = '{3'b011, 1, 1, 0, 0, 0, 0};

        set_all(32'h0000_0013, 0, 0, 0, 0, 1);
        do_reset();

        // add x3,x1,x2
        set_all(32'h0020_81B3, 0, 0, 0, 0, 1);
        es = '{S_FETCH, S_DECODE, S_EXEC_R, S_ALU_WB, S_FETCH, S_DECODE};
        for (int i = 0; i < 5; i++) begin
            chk("add_state", 32'(act[0].state), 32'(es[i]));
            chk("add_regwrite", 32'(act[0].reg_write), 32'(es[i] == S_ALU_WB));
            if (es[i] == S_EXEC_R) chk("add_aluctrl", 32'(act[0].alu_ctrl), 32'(ALU_ADD));
            tick();
        end

        // lw x5,0(x1) with memory stalled in MEM_READ
        do_reset();
        set_all(32'h0000_A283, 0, 0, 0, 0, 1);
        tick();
        tick();
        chk("lw_memaddr", 32'(act[0].state), 32'(S_MEM_ADDR));
        mrdy[0] = 1'b0; mrdy[1] = 1'b0;
        tick();
        for (int k = 0; k < 3; k++) begin
            chk("lw_wait_state", 32'(act[0].state), 32'(S_MEM_READ));
            chk("lw_wait_req", 32'({act[0].mem_req, act[0].adr_src}), 32'h3);
            tick();
            if (k == 0) chk("lw_nohs_state", 32'(act[1].state), 32'(S_MEM_WB));
        end
        chk("lw_still_read", 32'(act[0].state), 32'(S_MEM_READ));
        mrdy[0] = 1'b1;
        tick();
        chk("lw_wb", 32'(act[0]), 32'(exp_ctrl(S_MEM_WB, instr[0], 0, 0, 0, 0, 1, 1)));
        chk("lw_wb_fields", 32'({act[0].reg_write, act[0].mem_unsigned, act[0].mem_size}), 32'b1010);
        tick();
        chk("lw_done", 32'(act[0].state), 32'(S_FETCH));

        // Branch condition table, both parameterisations
        for (int i = 0; i < 13; i++) begin
            do_reset();
            set_all({7'd0, 5'd2, 5'd1, bv[i].f3, 5'd0, OP_BRANCH}, bv[i].z, bv[i].n, bv[i].v, bv[i].c, 1);
            tick();
            tick();
            chk($sformatf("br%0d_state", i), 32'(act[0].state), 32'(S_BRANCH));
            chk($sformatf("br%0d_taken_ovf", i), 32'(act[0].pc_write), 32'(bv[i].taken0));
            chk($sformatf("br%0d_taken_legacy", i), 32'(act[1].pc_write), 32'(bv[i].taken1));
            tick();
            chk($sformatf("br%0d_back", i), 32'(act[0].state), 32'(S_FETCH));
        end

        // jalr x1,0(x5)
        do_reset();
        set_all(32'h0002_80E7, 0, 0, 0, 0, 1);
        es = '{S_FETCH, S_DECODE, S_JALR_ADDR, S_JALR, S_ALU_WB, S_FETCH};
        for (int i = 0; i < 6; i++) begin
            chk("jalr_state", 32'(act[0].state), 32'(es[i]));
            if (es[i] == S_JALR)
                chk("jalr_ctrl", 32'({act[0].pc_write, act[0].src_a, act[0].src_b}), 32'b1_01_10);
            tick();
        end

        // Illegal opcode: parks in TRAP on instance 0, returns on instance 1
        do_reset();
        set_all(32'h0000_007F, 0, 0, 0, 0, 1);
        tick();
        tick();
        chk("trap_nopark_illegal", 32'(act[1].illegal), 32'h1);
        for (int i = 0; i < 10; i++) begin
            chk("trap_hold", 32'(act[0]), 32'(exp_ctrl(S_TRAP, instr[0], 0, 0, 0, 0, 1, 1)));
            tick();
            if (i == 0) chk("trap_nopark_state", 32'(act[1].state), 32'(S_FETCH));
        end
        rst_n = 1'b0;
        #1;
        chk("trap_async_reset", 32'(act[0].state), 32'(S_FETCH));
        chk("trap_async_illegal", 32'(act[0].illegal), 32'h0);
        rst_n = 1'b1;

        // sw x2,4(x1) abandoned by reset during MEM_WRITE
        do_reset();
        set_all(32'h0020_A223, 0, 0, 0, 0, 1);
        tick();
        tick();
        mrdy[0] = 1'b0;
        tick();
        chk("sw_write", 32'({act[0].state, act[0].mem_write}), 32'({S_MEM_WRITE, 1'b1}));
        tick();
        chk("sw_write_held", 32'({act[0].state, act[0].mem_write}), 32'({S_MEM_WRITE, 1'b1}));
        rst_n = 1'b0;
        #1;
        chk("sw_reset_memwrite", 32'(act[0].mem_write), 32'h0);
        chk("sw_reset_state", 32'(act[0].state), 32'(S_FETCH));
        rst_n = 1'b1;

        // Random instruction streams against the path model
        do_reset();
        need_new = '{1, 1};
        repeat (600) begin
            for (int d = 0; d < 2; d++) begin
                if (need_new[d]) begin
                    instr[d] = rand_instr(d == 1);
                    build_path(d, instr[d]);
                    need_new[d] = 0;
                end
                zf[d]   = 1'($urandom_range(0, 1));
                nf[d]   = 1'($urandom_range(0, 1));
                vf[d]   = 1'($urandom_range(0, 1));
                cf[d]   = 1'($urandom_range(0, 1));
                mrdy[d] = ($urandom_range(0, 3) != 0);
            end
            #1;
            for (int d = 0; d < 2; d++) begin
                ctrl_state_t cs;
                cs  = seq[d][seq_pos[d]];
                rdy = (d == 0) ? mrdy[d] : 1'b1;
                chk($sformatf("rand%0d", d), 32'(act[d]),
                    32'(exp_ctrl(cs, instr[d], zf[d], nf[d], vf[d], cf[d], rdy, d == 0)));
                if ((cs == S_FETCH || cs == S_MEM_READ || cs == S_MEM_WRITE) && !rdy) begin
                end else if (cs == S_TRAP && d == 0) begin
                end else begin
                    seq_pos[d]++;
                    if (seq_pos[d] == seq_len[d]) need_new[d] = 1;
                end
            end
            tick();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
